// File: rtl/exmem_skid_reg.sv
// exmem_skid_reg
// ---------------------------------------------------------------------------
// Generic pipeline-stage register with a valid/ready handshake and a
// two-entry skid buffer (main + skid). It sits between two pipeline stages.
// EX->MEM is the first user. Either side may stall independently without
// losing or duplicating a transfer. With out_ready_i tied to 1 it behaves
// like a plain stage register with one cycle of latency.
//
// Parameters
//   DATA_W    payload width
//   CTRL_MASK payload bits forced to 0 whenever the entry is not valid
//             (write enables, memory type and similar control fields)
//   RST_DATA  payload loaded by reset/flush, before CTRL_MASK is applied
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   in_valid_i   upstream offers in_data_i
//   in_data_i    upstream payload
//   in_ready_o   stage can accept; input fire = in_valid_i & in_ready_o
//   out_valid_o  main entry holds a valid payload
//   out_data_o   main entry payload (registered)
//   out_ready_i  downstream accepts
//   fc_stall_i   hold: blocks output transfer, input may still fill
//   fc_flush_i   discard all contents (overrides stall)
//   occupancy_o  number of valid entries, 0..2 (registered)
// ---------------------------------------------------------------------------
module exmem_skid_reg #(
  parameter int                 DATA_W    = 102,
  parameter logic [DATA_W-1:0]  CTRL_MASK = '0,
  parameter logic [DATA_W-1:0]  RST_DATA  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  input  logic              fc_stall_i,
  input  logic              fc_flush_i,
  output logic [1:0]        occupancy_o
);

  // Registered state
  logic              m_valid_reg, m_valid_next;
  logic [DATA_W-1:0] m_data_reg,  m_data_next;
  logic              s_valid_reg, s_valid_next;
  logic [DATA_W-1:0] s_data_reg,  s_data_next;
  logic [1:0]        occupancy_reg, occupancy_next;

  // Derived constants and helper vectors
  logic [DATA_W-1:0] clear_value;   // RST_DATA with control fields stripped
  logic [DATA_W-1:0] m_data_bubble; // main payload with control fields stripped

  logic in_fire;
  logic out_fire;

  // Per-bit masking: a control bit is forced to 0, any other bit passes.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
    assign clear_value[gi]   = CTRL_MASK[gi] ? 1'b0 : RST_DATA[gi];
    assign m_data_bubble[gi] = CTRL_MASK[gi] ? 1'b0 : m_data_reg[gi];
  end

  // Ready depends only on registered state and the two control inputs.
  // There is no path from in_valid_i or out_ready_i, so no combinational
  // loop can form through neighbouring stages.
  assign in_ready_o = !s_valid_reg && !fc_flush_i && !rst;
  assign in_fire    = in_valid_i && in_ready_o;
  assign out_fire   = m_valid_reg && out_ready_i && !fc_stall_i;

  always_comb begin
    m_valid_next = m_valid_reg;
    m_data_next  = m_data_reg;
    s_valid_next = s_valid_reg;
    s_data_next  = s_data_reg;

    if (rst || fc_flush_i) begin
      // Reset and flush drop everything.
      // in_ready_o is already low, so no input is taken this cycle.
      m_valid_next = 1'b0;
      m_data_next  = clear_value;
      s_valid_next = 1'b0;
      s_data_next  = clear_value;
    end else if (out_fire && s_valid_reg) begin
      // The skid entry is older than any new input.
      // in_ready_o is low whenever the skid is full.
      m_valid_next = 1'b1;
      m_data_next  = s_data_reg;
      s_valid_next = 1'b0;
    end else if (out_fire && in_fire) begin
      m_valid_next = 1'b1;
      m_data_next  = in_data_i;
    end else if (out_fire) begin
      // The stage drains to a bubble. Control bits are cleared.
      // Other bits hold their last value.
      m_valid_next = 1'b0;
      m_data_next  = m_data_bubble;
    end else if (in_fire && !m_valid_reg) begin
      m_valid_next = 1'b1;
      m_data_next  = in_data_i;
    end else if (in_fire) begin
      // Main is held (backpressure or stall), so the input parks in skid.
      s_valid_next = 1'b1;
      s_data_next  = in_data_i;
    end
  end

  assign occupancy_next = {1'b0, m_valid_next} + {1'b0, s_valid_next};

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_reg   <= 1'b0;
      m_data_reg    <= clear_value;
      s_valid_reg   <= 1'b0;
      s_data_reg    <= clear_value;
      occupancy_reg <= 2'd0;
    end else begin
      m_valid_reg   <= m_valid_next;
      m_data_reg    <= m_data_next;
      s_valid_reg   <= s_valid_next;
      s_data_reg    <= s_data_next;
      occupancy_reg <= occupancy_next;
    end
  end

  assign out_valid_o = m_valid_reg;
  assign out_data_o  = m_data_reg;
  assign occupancy_o = occupancy_reg;

endmodule

// File: tb/tb_exmem_skid_reg.sv
module tb_exmem_skid_reg;

  localparam int         DATA_W    = 8;
  localparam logic [7:0] CTRL_MASK = 8'h80;
  localparam logic [7:0] RST_DATA  = 8'h00;

  logic       clk;
  logic       rst;
  logic       in_valid_i;
  logic [7:0] in_data_i;
  logic       in_ready_o;
  logic       out_valid_o;
  logic [7:0] out_data_o;
  logic       out_ready_i;
  logic       fc_stall_i;
  logic       fc_flush_i;
  logic [1:0] occupancy_o;

  int checks_cnt;
  int errors_cnt;

  exmem_skid_reg #(
    .DATA_W    (DATA_W),
    .CTRL_MASK (CTRL_MASK),
    .RST_DATA  (RST_DATA)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .fc_stall_i  (fc_stall_i),
    .fc_flush_i  (fc_flush_i),
    .occupancy_o (occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the three registered outputs together.
  task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] occ);
    check({tag, ".valid"}, {15'd0, out_valid_o}, {15'd0, v});
    check({tag, ".data"},  {8'd0, out_data_o},   {8'd0, d});
    check({tag, ".occ"},   {14'd0, occupancy_o}, {14'd0, occ});
    $display("txn %-10s valid=%0b data=0x%02h occ=%0d in_ready=%0b",
             tag, out_valid_o, out_data_o, occupancy_o, in_ready_o);
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    in_valid_i = v;
    in_data_i  = d;
  endtask

  initial begin
    checks_cnt  = 0;
    errors_cnt  = 0;
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    in_data_i   = 8'h00;
    out_ready_i = 1'b0;
    fc_stall_i  = 1'b0;
    fc_flush_i  = 1'b0;

    // Reset
    step();
    step();
    check("rst_ready", {15'd0, in_ready_o}, 16'd0);
    check_out("reset", 1'b0, 8'h00, 2'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {15'd0, in_ready_o}, 16'd1);

    // Streaming
    out_ready_i = 1'b1;
    drive(1'b1, 8'h11); step(); check_out("strm_11", 1'b1, 8'h11, 2'd1);
    check("strm_rdy1", {15'd0, in_ready_o}, 16'd1);
    drive(1'b1, 8'h12); step(); check_out("strm_12", 1'b1, 8'h12, 2'd1);
    check("strm_rdy2", {15'd0, in_ready_o}, 16'd1);
    drive(1'b1, 8'h13); step(); check_out("strm_13", 1'b1, 8'h13, 2'd1);
    check("strm_rdy3", {15'd0, in_ready_o}, 16'd1);
    drive(1'b0, 8'h00); step(); check_out("strm_end", 1'b0, 8'h13, 2'd0);

    // Backpressure and skid
    out_ready_i = 1'b0;
    drive(1'b1, 8'h21); step(); check_out("bp_21", 1'b1, 8'h21, 2'd1);
    check("bp_rdy1", {15'd0, in_ready_o}, 16'd1);
    drive(1'b1, 8'h22); step(); check_out("bp_full", 1'b1, 8'h21, 2'd2);
    check("bp_rdy_low", {15'd0, in_ready_o}, 16'd0);
    drive(1'b0, 8'h00);
    out_ready_i = 1'b1;
    step(); check_out("bp_22", 1'b1, 8'h22, 2'd1);
    check("bp_rdy_back", {15'd0, in_ready_o}, 16'd1);
    step(); check_out("bp_empty", 1'b0, 8'h22, 2'd0);

    // Bubble masking of the control bit
    drive(1'b1, 8'h85); step(); check_out("bub_85", 1'b1, 8'h85, 2'd1);
    drive(1'b0, 8'h00); step(); check_out("bub_mask", 1'b0, 8'h05, 2'd0);

    // Stall: accepts into empty entries, holds output
    fc_stall_i = 1'b1;
    drive(1'b1, 8'h31); step(); check_out("stl_31", 1'b1, 8'h31, 2'd1);
    drive(1'b1, 8'h32); step(); check_out("stl_hold", 1'b1, 8'h31, 2'd2);
    check("stl_rdy_low", {15'd0, in_ready_o}, 16'd0);
    drive(1'b0, 8'h00);
    fc_stall_i = 1'b0;
    step(); check_out("stl_32", 1'b1, 8'h32, 2'd1);
    step(); check_out("stl_empty", 1'b0, 8'h32, 2'd0);

    // Flush overrides stall and drops the concurrent input
    out_ready_i = 1'b0;
    drive(1'b1, 8'h41); step();
    drive(1'b1, 8'h42); step(); check_out("fl_full", 1'b1, 8'h41, 2'd2);
    fc_flush_i = 1'b1;
    fc_stall_i = 1'b1;
    drive(1'b1, 8'h44);
    #1;
    check("fl_rdy_low", {15'd0, in_ready_o}, 16'd0);
    step(); check_out("fl_done", 1'b0, 8'h00, 2'd0);
    fc_flush_i  = 1'b0;
    fc_stall_i  = 1'b0;
    out_ready_i = 1'b1;
    drive(1'b0, 8'h00);
    step(); check_out("fl_no44", 1'b0, 8'h00, 2'd0);

    // Synchronous reset mid-stream
    out_ready_i = 1'b0;
    drive(1'b1, 8'h51); step();
    drive(1'b1, 8'h52); step(); check_out("rs_full", 1'b1, 8'h51, 2'd2);
    drive(1'b0, 8'h00);
    rst = 1'b1;
    #1;
    check("rs_rdy_high", {15'd0, in_ready_o}, 16'd0);
    step(); check_out("rs_done", 1'b0, 8'h00, 2'd0);
    check("rs_rdy_hold", {15'd0, in_ready_o}, 16'd0);
    rst = 1'b0;
    #1;
    check("rs_rdy_back", {15'd0, in_ready_o}, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
